// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// Presents the PC to the instruction cache every cycle, pushes hits into the
// instruction queue, services misses through the memory controller (refill +
// deliver), and handles redirects, including one that lands mid-miss.
// Optional macro FETCH_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  queue_full,
    output logic [ADDR_WIDTH-1:0] ic_addr,
    input  logic                  ic_hit,
    input  logic [31:0]           ic_inst,
    output logic                  ic_store_en,
    output logic [ADDR_WIDTH-1:0] ic_store_addr,
    output logic [31:0]           ic_store_inst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_done,
    input  logic [31:0]           mem_data,
    output logic                  inst_valid,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    // LOOKUP: probing the cache; MISS: waiting for our own word;
    // DRAIN: waiting for a word whose delivery was cancelled by a redirect.
    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_MISS   = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_store_en;
    logic [ADDR_WIDTH-1:0] r_store_addr;
    logic [31:0]           r_store_inst;
    logic                  r_inst_valid;
    logic [31:0]           r_inst_out;
    logic [ADDR_WIDTH-1:0] r_inst_pc;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + ADDR_WIDTH'(4);

    // Sequencer: reset beats rdy; rdy low freezes every register, pulses included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOOKUP;
            r_pc         <= RESET_PC[ADDR_WIDTH-1:0];
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_store_en   <= 1'b0;
            r_store_addr <= '0;
            r_store_inst <= '0;
            r_inst_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_pc    <= '0;
        end else if (rdy) begin
            r_store_en   <= 1'b0;
            r_inst_valid <= 1'b0;
            case (r_state)
                S_LOOKUP: begin
                    if (flush) begin
                        r_pc <= flush_pc;
                    end else if (queue_full) begin
                        r_pc <= r_pc;
                    end else if (ic_hit) begin
                        r_inst_valid <= 1'b1;
                        r_inst_out   <= ic_inst;
                        r_inst_pc    <= r_pc;
                        r_pc         <= w_pc_inc;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_state    <= S_MISS;
                    end
                end
                S_MISS: begin
                    // The returned word always refills the cache; it is only
                    // delivered to the queue if no redirect arrived with it.
                    if (mem_done) begin
                        r_mem_req    <= 1'b0;
                        r_store_en   <= 1'b1;
                        r_store_addr <= r_mem_addr;
                        r_store_inst <= mem_data;
                        r_state      <= S_LOOKUP;
                        if (flush) begin
                            r_pc <= flush_pc;
                        end else begin
                            r_inst_valid <= 1'b1;
                            r_inst_out   <= mem_data;
                            r_inst_pc    <= r_pc;
                            r_pc         <= w_pc_inc;
                        end
                    end else if (flush) begin
                        r_pc    <= flush_pc;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (flush) begin
                        r_pc <= flush_pc;
                    end
                    if (mem_done) begin
                        r_mem_req    <= 1'b0;
                        r_store_en   <= 1'b1;
                        r_store_addr <= r_mem_addr;
                        r_store_inst <= mem_data;
                        r_state      <= S_LOOKUP;
                    end
                end
                default: begin
                    r_state <= S_LOOKUP;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Performance counters: LOOKUP hits pushed, and LOOKUP->MISS transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy && r_state == S_LOOKUP && !flush && !queue_full) begin
            if (ic_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign ic_addr       = r_pc;
    assign ic_store_en   = r_store_en;
    assign ic_store_addr = r_store_addr;
    assign ic_store_inst = r_store_inst;
    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign inst_valid    = r_inst_valid;
    assign inst_out      = r_inst_out;
    assign inst_pc       = r_inst_pc;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: table of per-cycle input/expected-output records
// applied in a loop, followed by hand-written reset sequences.
`timescale 1ns/1ps
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        queue_full = 1'b0;
    logic [31:0] ic_addr;
    logic        ic_hit = 1'b0;
    logic [31:0] ic_inst = '0;
    logic        ic_store_en;
    logic [31:0] ic_store_addr;
    logic [31:0] ic_store_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_ctrl #(.RESET_PC(32'h0), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flush_pc(flush_pc),
        .queue_full(queue_full), .ic_addr(ic_addr), .ic_hit(ic_hit),
        .ic_inst(ic_inst), .ic_store_en(ic_store_en),
        .ic_store_addr(ic_store_addr), .ic_store_inst(ic_store_inst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done),
        .mem_data(mem_data), .inst_valid(inst_valid), .inst_out(inst_out),
        .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    typedef struct {
        logic        rdy;
        logic        flush;
        logic [31:0] fpc;
        logic        qf;
        logic        hit;
        logic [31:0] inst;
        logic        done;
        logic [31:0] mdata;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_maddr;
        logic        e_se;
        logic [31:0] e_saddr;
        logic [31:0] e_sinst;
        logic        e_iv;
        logic [31:0] e_iout;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic f, logic [31:0] fp, logic q,
                                logic h, logic [31:0] in, logic d, logic [31:0] md,
                                logic [31:0] pc, logic rq, logic [31:0] ma,
                                logic se, logic [31:0] sa, logic [31:0] si,
                                logic iv, logic [31:0] io, logic [31:0] ip);
        vec_t v;
        v.rdy = r; v.flush = f; v.fpc = fp; v.qf = q; v.hit = h; v.inst = in;
        v.done = d; v.mdata = md; v.e_pc = pc; v.e_req = rq; v.e_maddr = ma;
        v.e_se = se; v.e_saddr = sa; v.e_sinst = si; v.e_iv = iv;
        v.e_iout = io; v.e_ipc = ip;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // rdy flush fpc qf hit inst done mdata | pc req maddr se saddr sinst iv iout ipc
        // Continuous hits from reset: ic_inst = pc ^ A5A5A5A5
        vq.push_back(mk(1,0,0,0,1,32'hA5A5A5A5,0,0, 32'h4,0,0,0,0,0,1,32'hA5A5A5A5,32'h0));
        vq.push_back(mk(1,0,0,0,1,32'hA5A5A5A1,0,0, 32'h8,0,0,0,0,0,1,32'hA5A5A5A1,32'h4));
        vq.push_back(mk(1,0,0,0,1,32'hA5A5A5AD,0,0, 32'hC,0,0,0,0,0,1,32'hA5A5A5AD,32'h8));
        vq.push_back(mk(1,0,0,0,1,32'hA5A5A5A9,0,0, 32'h10,0,0,0,0,0,1,32'hA5A5A5A9,32'hC));
        // Redirect to 0x100 (flush beats hit)
        vq.push_back(mk(1,1,32'h100,0,1,32'hCAFECAFE,0,0, 32'h100,0,0,0,0,0,0,32'hA5A5A5A9,32'hC));
        // Miss at 0x100: request held 5 cycles, then done
        vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h100,1,32'h100,0,0,0,0,32'hA5A5A5A9,32'hC));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h100,1,32'h100,0,0,0,0,32'hA5A5A5A9,32'hC));
        vq.push_back(mk(1,0,0,0,0,0,1,32'h00500093, 32'h104,0,32'h100,1,32'h100,32'h00500093,1,32'h00500093,32'h100));
        vq.push_back(mk(1,0,0,0,1,32'h11111111,0,0, 32'h108,0,32'h100,0,32'h100,32'h00500093,1,32'h11111111,32'h104));
        // Miss at 0x100 redirected to 0x200 two cycles in; drained refill
        vq.push_back(mk(1,1,32'h100,0,0,0,0,0, 32'h100,0,32'h100,0,32'h100,32'h00500093,0,32'h11111111,32'h104));
        vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h100,1,32'h100,0,32'h100,32'h00500093,0,32'h11111111,32'h104));
        vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h100,1,32'h100,0,32'h100,32'h00500093,0,32'h11111111,32'h104));
        vq.push_back(mk(1,1,32'h200,0,0,0,0,0, 32'h200,1,32'h100,0,32'h100,32'h00500093,0,32'h11111111,32'h104));
        vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h200,1,32'h100,0,32'h100,32'h00500093,0,32'h11111111,32'h104));
        vq.push_back(mk(1,0,0,0,0,0,1,32'hDEADBEEF, 32'h200,0,32'h100,1,32'h100,32'hDEADBEEF,0,32'h11111111,32'h104));
        vq.push_back(mk(1,0,0,0,1,32'h22222222,0,0, 32'h204,0,32'h100,0,32'h100,32'hDEADBEEF,1,32'h22222222,32'h200));
        // queue_full for 3 cycles at 0x40
        vq.push_back(mk(1,1,32'h40,0,0,0,0,0, 32'h40,0,32'h100,0,32'h100,32'hDEADBEEF,0,32'h22222222,32'h200));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1,0,0,1,1,32'h33333333,0,0, 32'h40,0,32'h100,0,32'h100,32'hDEADBEEF,0,32'h22222222,32'h200));
        vq.push_back(mk(1,0,0,0,1,32'h33333333,0,0, 32'h44,0,32'h100,0,32'h100,32'hDEADBEEF,1,32'h33333333,32'h40));
        // Flush coincident with hit, to 0x80
        vq.push_back(mk(1,1,32'h80,0,1,32'h44444444,0,0, 32'h80,0,32'h100,0,32'h100,32'hDEADBEEF,0,32'h33333333,32'h40));
        vq.push_back(mk(1,0,0,0,1,32'h55555555,0,0, 32'h84,0,32'h100,0,32'h100,32'hDEADBEEF,1,32'h55555555,32'h80));
        // Miss at 0x84 with flush and mem_done in the same cycle
        vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h84,1,32'h84,0,32'h100,32'hDEADBEEF,0,32'h55555555,32'h80));
        vq.push_back(mk(1,1,32'h300,0,0,0,1,32'h66666666, 32'h300,0,32'h84,1,32'h84,32'h66666666,0,32'h55555555,32'h80));
        // PC wrap FFFFFFFC -> 0
        vq.push_back(mk(1,1,32'hFFFFFFFC,0,0,0,0,0, 32'hFFFFFFFC,0,32'h84,0,32'h84,32'h66666666,0,32'h55555555,32'h80));
        vq.push_back(mk(1,0,0,0,1,32'h77777777,0,0, 32'h0,0,32'h84,0,32'h84,32'h66666666,1,32'h77777777,32'hFFFFFFFC));
        // Miss at 0, two flushes while draining
        vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h0,1,32'h0,0,32'h84,32'h66666666,0,32'h77777777,32'hFFFFFFFC));
        vq.push_back(mk(1,1,32'h400,0,0,0,0,0, 32'h400,1,32'h0,0,32'h84,32'h66666666,0,32'h77777777,32'hFFFFFFFC));
        vq.push_back(mk(1,1,32'h500,0,0,0,0,0, 32'h500,1,32'h0,0,32'h84,32'h66666666,0,32'h77777777,32'hFFFFFFFC));
        vq.push_back(mk(1,0,0,0,0,0,1,32'h88888888, 32'h500,0,32'h0,1,32'h0,32'h88888888,0,32'h77777777,32'hFFFFFFFC));
        // rdy=0 holds an inst_valid pulse
        vq.push_back(mk(1,0,0,0,1,32'h99999999,0,0, 32'h504,0,32'h0,0,32'h0,32'h88888888,1,32'h99999999,32'h500));
        vq.push_back(mk(0,0,0,0,1,32'hAAAAAAAA,0,0, 32'h504,0,32'h0,0,32'h0,32'h88888888,1,32'h99999999,32'h500));
        // Miss at 0x504, then rdy=0 for 4 cycles with a flush presented
        vq.push_back(mk(1,0,0,0,0,0,0,0, 32'h504,1,32'h504,0,32'h0,32'h88888888,0,32'h99999999,32'h500));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0,1,32'h900,0,0,0,0,0, 32'h504,1,32'h504,0,32'h0,32'h88888888,0,32'h99999999,32'h500));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", -1, ic_addr, 32'h0);
        chk("reset_mem_req", -1, {31'b0, mem_req}, 32'h0);
        chk("reset_inst_valid", -1, {31'b0, inst_valid}, 32'h0);
        chk("reset_store_en", -1, {31'b0, ic_store_en}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            rdy = vq[i].rdy; flush = vq[i].flush; flush_pc = vq[i].fpc;
            queue_full = vq[i].qf; ic_hit = vq[i].hit; ic_inst = vq[i].inst;
            mem_done = vq[i].done; mem_data = vq[i].mdata;
            @(posedge clk);
            #1;
            $display("vec %0d: ic_addr=%h mem_req=%b mem_addr=%h store_en=%b inst_valid=%b inst_out=%h inst_pc=%h",
                     i, ic_addr, mem_req, mem_addr, ic_store_en, inst_valid, inst_out, inst_pc);
            chk("ic_addr", i, ic_addr, vq[i].e_pc);
            chk("mem_req", i, {31'b0, mem_req}, {31'b0, vq[i].e_req});
            chk("mem_addr", i, mem_addr, vq[i].e_maddr);
            chk("ic_store_en", i, {31'b0, ic_store_en}, {31'b0, vq[i].e_se});
            chk("ic_store_addr", i, ic_store_addr, vq[i].e_saddr);
            chk("ic_store_inst", i, ic_store_inst, vq[i].e_sinst);
            chk("inst_valid", i, {31'b0, inst_valid}, {31'b0, vq[i].e_iv});
            chk("inst_out", i, inst_out, vq[i].e_iout);
            chk("inst_pc", i, inst_pc, vq[i].e_ipc);
            @(negedge clk);
        end

`ifdef FETCH_PERF_CNT_EN
        chk("hit_cnt", -2, hit_cnt, 32'd10);
        chk("miss_cnt", -2, miss_cnt, 32'd5);
`endif

        // Reset while a miss is outstanding and frozen
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; mem_done = 1'b0; ic_hit = 1'b0;
        @(posedge clk);
        #1;
        $display("reset mid-miss: ic_addr=%h mem_req=%b mem_addr=%h inst_valid=%b", ic_addr, mem_req, mem_addr, inst_valid);
        chk("rst_pc", -3, ic_addr, 32'h0);
        chk("rst_mem_req", -3, {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", -3, mem_addr, 32'h0);
        chk("rst_store_addr", -3, ic_store_addr, 32'h0);
        chk("rst_inst_out", -3, inst_out, 32'h0);
        chk("rst_inst_pc", -3, inst_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_hit_cnt", -3, hit_cnt, 32'h0);
        chk("rst_miss_cnt", -3, miss_cnt, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Back in LOOKUP after reset: a hit at RESET_PC is delivered
        ic_hit = 1'b1; ic_inst = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        $display("post-reset hit: ic_addr=%h inst_valid=%b inst_out=%h inst_pc=%h", ic_addr, inst_valid, inst_out, inst_pc);
        chk("post_rst_valid", -4, {31'b0, inst_valid}, 32'h1);
        chk("post_rst_inst", -4, inst_out, 32'hA5A5A5A5);
        chk("post_rst_pc", -4, ic_addr, 32'h4);
        @(negedge clk);
        ic_hit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer between the PC, the direct-mapped instruction cache and the memory controller.
- Each cycle it presents the current PC to the cache lookup port.
- On a hit it pushes the instruction into the instruction queue.
- On a miss it issues a word read to the memory controller, refills the cache, then delivers the instruction.
- It handles redirects (flush) from the branch/commit logic, including a redirect that arrives while a miss is outstanding.

Parameters:
RESET_PC, 32'h0, PC loaded on reset
ADDR_WIDTH, 32, PC/address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; when low the block freezes
flush  in  1  redirect request
flush_pc  in  32  redirect target
queue_full  in  1  instruction queue cannot accept a push
ic_addr  out  32  cache lookup address, combinationally equal to pc
ic_hit  in  1  lookup hit (combinational from cache)
ic_inst  in  32  lookup data
ic_store_en  out  1  cache refill write strobe
ic_store_addr  out  32  refill address
ic_store_inst  out  32  refill data
mem_req  out  1  read request, held until mem_done
mem_addr  out  32  read address
mem_done  in  1  one-cycle pulse, mem_data valid
mem_data  in  32  fetched word
inst_valid  out  1  one-cycle push into queue
inst_out  out  32  instruction
inst_pc  out  32  its PC

Behaviour:
- Reset (rst=1 at posedge) overrides everything:
  - pc=RESET_PC, state=LOOKUP.
  - mem_req=0, mem_addr=0, ic_store_en=0, ic_store_addr=0, ic_store_inst=0.
  - inst_valid=0, inst_out=0, inst_pc=0.
- Reset mid-miss abandons the request. The memory controller shares rst.
- All outputs except ic_addr are registered. inst_valid and ic_store_en default to 0 every active cycle; they are pulses.
- rdy=0: no state, pc or output register changes. Pulses already high are held; the consumers are also rdy-gated. The memory controller does not pulse mem_done while rdy=0.
- State LOOKUP:
  - flush=1: pc<=flush_pc; no push, no request. Flush has priority over hit/miss.
  - Else if queue_full: hold, no push, no request.
  - Else if ic_hit: inst_valid<=1, inst_out<=ic_inst, inst_pc<=pc, pc<=pc+4 (mod 2^32). Hit throughput is 1 instruction per cycle; data appears the cycle after lookup.
  - Else (miss): mem_req<=1, mem_addr<=pc, state<=MISS.
- State MISS (mem_req held high, mem_addr stable):
  - mem_done=1 and flush=0:
    - mem_req<=0.
    - Refill: ic_store_en<=1, ic_store_addr<=pc, ic_store_inst<=mem_data.
    - Push: inst_valid<=1, inst_out<=mem_data, inst_pc<=pc.
    - pc<=pc+4, state<=LOOKUP.
    - queue_full is not rechecked; the queue guarantees one free slot after full was low at issue.
  - flush=1 (mem_done 0 or 1): pc<=flush_pc.
    - If mem_done=1 that cycle: refill cache only, no push, mem_req<=0, state<=LOOKUP.
    - Otherwise state<=DRAIN.
- State DRAIN (request still outstanding, result discarded):
  - mem_req stays high until mem_done.
  - On mem_done: refill cache with mem_addr/mem_data (the data is correct for that address), no push, mem_req<=0, state<=LOOKUP.
  - A further flush in DRAIN only updates pc.
- The refill write takes effect the cycle after ic_store_en, so a lookup of the same address in the cycle of the write misses. This is allowed; the result is a second refill of the same data.
- PC increment wraps 32'hFFFFFFFC -> 0.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0, both wrapping.
  - hit_cnt increments on each LOOKUP push.
  - miss_cnt increments on each LOOKUP->MISS transition, including misses later flushed.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset with RESET_PC=0, cache always hit with ic_inst=PC^32'hA5A5A5A5 -> inst_valid every cycle, inst_pc=0,4,8,12, inst_out matches.
- Miss at pc=0x100, mem_done 5 cycles after request with mem_data=0x00500093 -> mem_addr=0x100 held 5 cycles; then ic_store_en=1 (addr 0x100, data 0x00500093), inst_valid=1 same cycle, next ic_addr=0x104.
- Flush to 0x200 two cycles into a miss at 0x100, mem_done later -> no inst_valid for 0x100, cache refilled at 0x100, next lookup at 0x200.
- queue_full=1 for 3 cycles while hitting at 0x40 -> no pushes and pc stays 0x40; push of 0x40 on the first cycle after full drops.
- Flush coincident with a hit in LOOKUP (flush_pc=0x80) -> no push, next ic_addr=0x80.
- rdy=0 for 4 cycles during MISS with rst asserted afterwards -> state frozen during rdy=0; after rst: pc=RESET_PC, mem_req=0, and with FETCH_PERF_CNT_EN both counters=0.
